// File: rtl/rggen_counter_pkg.sv
// Shared types and the delta helper for the extended rggen bit-field counter.
package rggen_counter_pkg;
    typedef enum logic {
        RGGEN_COUNTER_WRAP     = 1'b0,
        RGGEN_COUNTER_SATURATE = 1'b1
    } rggen_counter_mode_e;

    localparam int RGGEN_COUNTER_MAX_WIDTH = 32;

    // Wide enough for any WIDTH up to 32 plus carry and sign; callers slice to WIDTH+2.
    typedef logic signed [RGGEN_COUNTER_MAX_WIDTH+1:0] rggen_counter_delta_t;

    function automatic rggen_counter_delta_t rggen_counter_calc_delta(
        input logic                               up,
        input logic [RGGEN_COUNTER_MAX_WIDTH-1:0] up_step,
        input logic                               down,
        input logic [RGGEN_COUNTER_MAX_WIDTH-1:0] down_step
    );
        rggen_counter_delta_t d_up;
        rggen_counter_delta_t d_down;
        d_up   = up   ? $signed({2'b00, up_step})   : '0;
        d_down = down ? $signed({2'b00, down_step}) : '0;
        return d_up - d_down;
    endfunction
endpackage

// File: rtl/rggen_bit_field_if.sv
// Software access channel between the register block and one bit field.
interface rggen_bit_field_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] read_data;

    modport master (
        output valid, write_mask, write_data,
        input  value, read_data
    );

    modport slave (
        input  valid, write_mask, write_data,
        output value, read_data
    );

    modport bit_field (
        input  valid, write_mask, write_data,
        output value, read_data
    );
endinterface

// File: rtl/rggen_counter_next_value.sv
// Combinational next-count calculation: applies a signed delta with wrap or saturate handling.
module rggen_counter_next_value
    import rggen_counter_pkg::*;
#(
    parameter int                  WIDTH     = 8,
    parameter rggen_counter_mode_e MODE      = RGGEN_COUNTER_WRAP,
    parameter logic [WIDTH-1:0]    MAX_VALUE = '1
)(
    input  logic [WIDTH-1:0]        i_count,
    input  logic signed [WIDTH+1:0] i_delta,
    output logic [WIDTH-1:0]        o_next_count,
    output logic                    o_overflow,
    output logic                    o_underflow
);
    localparam logic signed [WIDTH+1:0] MAX_EXT = $signed({2'b00, MAX_VALUE});

    logic signed [WIDTH+1:0] sum;
    logic                    negative;

    // Operand ranges keep the sum within WIDTH+2 signed bits, so no overflow here.
    assign sum      = $signed({2'b00, i_count}) + i_delta;
    assign negative = sum[WIDTH+1];

    generate
        if (MODE == RGGEN_COUNTER_SATURATE) begin : g_saturate
            always_comb begin
                o_overflow   = 1'b0;
                o_underflow  = 1'b0;
                o_next_count = sum[WIDTH-1:0];
                if (negative) begin
                    o_underflow  = 1'b1;
                    o_next_count = '0;
                end else if (sum > MAX_EXT) begin
                    o_overflow   = 1'b1;
                    o_next_count = MAX_VALUE;
                end
            end
        end else begin : g_wrap
            assign o_next_count = sum[WIDTH-1:0];
            assign o_underflow  = negative;
            assign o_overflow   = !negative && sum[WIDTH];
        end
    endgenerate
endmodule

// File: rtl/rggen_bit_field_counter_ex.sv
// Bit-field counter with multi-step up/down, wrap/saturate, sticky flags and threshold pulse.
module rggen_bit_field_counter_ex
    import rggen_counter_pkg::*;
#(
    parameter int                  WIDTH         = 8,
    parameter int                  STEP_WIDTH    = 1,
    parameter logic [WIDTH-1:0]    INITIAL_VALUE = '0,
    parameter rggen_counter_mode_e MODE          = RGGEN_COUNTER_WRAP,
    parameter logic [WIDTH-1:0]    MAX_VALUE     = '1,
    parameter logic [WIDTH-1:0]    THRESHOLD     = '1
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    rggen_bit_field_if.bit_field  bit_field_if,
    input  logic                  i_clear,
    input  logic                  i_up,
    input  logic [STEP_WIDTH-1:0] i_up_step,
    input  logic                  i_down,
    input  logic [STEP_WIDTH-1:0] i_down_step,
    input  logic                  i_flag_clear,
    output logic [WIDTH-1:0]      o_count,
    output logic                  o_overflow,
    output logic                  o_underflow,
    output logic                  o_threshold_hit
);
    logic [WIDTH-1:0]        count;
    logic [WIDTH-1:0]        count_next;
    logic [WIDTH-1:0]        hw_count;
    logic                    hw_overflow;
    logic                    hw_underflow;
    logic                    sw_write;
    logic                    hw_event;
    logic                    set_overflow;
    logic                    set_underflow;
    rggen_counter_delta_t    delta_full;
    logic signed [WIDTH+1:0] delta;

    assign delta_full = rggen_counter_calc_delta(
        i_up,   RGGEN_COUNTER_MAX_WIDTH'(i_up_step),
        i_down, RGGEN_COUNTER_MAX_WIDTH'(i_down_step)
    );
    assign delta = delta_full[WIDTH+1:0];

    rggen_counter_next_value #(
        .WIDTH     (WIDTH),
        .MODE      (MODE),
        .MAX_VALUE (MAX_VALUE)
    ) u_next_value (
        .i_count      (count),
        .i_delta      (delta),
        .o_next_count (hw_count),
        .o_overflow   (hw_overflow),
        .o_underflow  (hw_underflow)
    );

    assign sw_write = bit_field_if.valid && (bit_field_if.write_mask != '0);
    assign hw_event = i_up || i_down;

    // Hardware counting only takes effect when neither clear nor a write owns the cycle.
    assign set_overflow  = !i_clear && !sw_write && hw_event && hw_overflow;
    assign set_underflow = !i_clear && !sw_write && hw_event && hw_underflow;

    always_comb begin
        count_next = count;
        if (i_clear) begin
            count_next = INITIAL_VALUE;
        end else if (sw_write) begin
            count_next = (bit_field_if.write_data & bit_field_if.write_mask)
                       | (count & ~bit_field_if.write_mask);
        end else if (hw_event) begin
            count_next = hw_count;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count           <= INITIAL_VALUE;
            o_overflow      <= 1'b0;
            o_underflow     <= 1'b0;
            o_threshold_hit <= 1'b0;
        end else begin
            count           <= count_next;
            o_overflow      <= !i_clear && (set_overflow  || (o_overflow  && !i_flag_clear));
            o_underflow     <= !i_clear && (set_underflow || (o_underflow && !i_flag_clear));
            o_threshold_hit <= (count < THRESHOLD) && (count_next >= THRESHOLD);
        end
    end

    assign o_count                = count;
    assign bit_field_if.value     = count;
    assign bit_field_if.read_data = count;
endmodule
